period_meter: RTL and testbench

PERIOD_METER -- requirements
Module: period_meter

---
 rtl/period_meter.sv | 222 ++++++++++++++++++++++
 tb/tb_period_meter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/period_meter.sv
`timescale 1ns/1ps
// period_meter
// Measures the period (and optionally the high time) of an asynchronous
// input in clk cycles. One measurement per accepted start pulse; the result
// is held with valid=1 until the consumer acknowledges it. A measurement
// that sees no closing edge within TMO cycles reports timeout instead.
//
// Build option: define PERIOD_METER_DUTY_EN to enable high-time measurement.
// Without it the high-time counter is not built and high_time reads 0.
module period_meter #(
  parameter int          CNT_W = 33,
  parameter logic [63:0] TMO   = 64'd1048576
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             start,
  input  logic             ack,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             valid,
  output logic             busy,
  output logic             timeout
);

  // Last count value before the measurement is abandoned.
  localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TMO - 64'd1);
  localparam logic [CNT_W-1:0] ONES     = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    MEAS = 2'd2,
    DONE = 2'd3
  } state_t;

  // Counter increment. The timeout fires at TMO-1, which is below the
  // all-ones value, so the counters never need to wrap.
  function automatic logic [CNT_W-1:0] inc_cnt(input logic [CNT_W-1:0] v);
    return v + CNT_W'(1);
  endfunction

  // Period result: the closing rise is seen while cnt still holds N-1.
  function automatic logic [CNT_W-1:0] period_of(input logic [CNT_W-1:0] c);
    return inc_cnt(c);
  endfunction

  state_t           state;
  state_t           state_nxt;
  logic             sync_p0;
  logic             sync_p1;
  logic             sig_p2;
  logic             rise;
  logic [CNT_W-1:0] cnt;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             ld_meas;
  logic             ld_tmo;
  logic             vld_clr;
  logic             at_limit;

  // ---- stage p0/p1: two-flop synchronizer for the asynchronous input ----
  // ---- stage p2: edge-detector history flop ----
  // Synchronize sig_in and keep one cycle of history for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sig_p2  <= 1'b0;
    end else begin
      sync_p0 <= sig_in;
      sync_p1 <= sync_p0;
      sig_p2  <= sync_p1;
    end
  end

  // One-cycle rise pulse on the synchronized input.
  assign rise     = sync_p1 & ~sig_p2;
  assign at_limit = (cnt == TMO_LAST);
  assign busy     = (state == ARM) || (state == MEAS);

  // ---- control: measurement state machine ----
  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    state_nxt = state;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    ld_meas   = 1'b0;
    ld_tmo    = 1'b0;
    vld_clr   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_clr   = 1'b1;
          state_nxt = ARM;
        end
      end
      ARM: begin
        // A rise on the last allowed cycle still starts the measurement.
        if (rise) begin
          cnt_clr   = 1'b1;
          state_nxt = MEAS;
        end else if (at_limit) begin
          ld_tmo    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      MEAS: begin
        // The closing rise wins over a simultaneous timeout.
        if (rise) begin
          ld_meas   = 1'b1;
          state_nxt = DONE;
        end else if (at_limit) begin
          ld_tmo    = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_inc   = 1'b1;
        end
      end
      DONE: begin
        // Outputs hold until ack; ack together with start re-arms at once.
        if (ack) begin
          vld_clr = 1'b1;
          if (start) begin
            cnt_clr   = 1'b1;
            state_nxt = ARM;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // ---- datapath: measurement counter ----
  // Cycle counter shared by the arming wait and the period measurement.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_inc) begin
      cnt <= inc_cnt(cnt);
    end
  end

  // ---- result registers ----
  // Period, timeout flag and valid handshake.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      period  <= '0;
      timeout <= 1'b0;
      valid   <= 1'b0;
    end else if (ld_meas) begin
      period  <= period_of(cnt);
      timeout <= 1'b0;
      valid   <= 1'b1;
    end else if (ld_tmo) begin
      period  <= ONES;
      timeout <= 1'b1;
      valid   <= 1'b1;
    end else if (vld_clr) begin
      valid   <= 1'b0;
    end
  end

`ifdef PERIOD_METER_DUTY_EN
  logic [CNT_W-1:0] hcnt;
  logic             fell_seen;
  logic             fall;

  assign fall = ~sync_p1 & sig_p2;

  // High-time counter: counts cycles where the history flop is high after
  // the opening rise, including the cycle that reports the fall, then
  // freezes for the rest of the period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hcnt      <= '0;
      fell_seen <= 1'b0;
    end else if ((state == ARM) && rise) begin
      hcnt      <= '0;
      fell_seen <= 1'b0;
    end else if (state == MEAS) begin
      if (sig_p2 && !fell_seen) begin
        hcnt <= inc_cnt(hcnt);
      end
      if (fall) begin
        fell_seen <= 1'b1;
      end
    end
  end

  // High-time result, captured alongside period.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      high_time <= '0;
    end else if (ld_meas) begin
      high_time <= fell_seen ? hcnt : inc_cnt(hcnt);
    end else if (ld_tmo) begin
      high_time <= '0;
    end
  end
`else
  assign high_time = '0;
`endif

endmodule

// File: tb/tb_period_meter.sv
`timescale 1ns/1ps
// tb_period_meter: directed and randomized checks of period_meter with TMO=64.
module tb_period_meter;

  localparam int          CNT_W = 33;
  localparam logic [63:0] ALL1  = (64'd1 << CNT_W) - 64'd1;

  logic             clk;
  logic             rst;
  logic             sig_in;
  logic             start;
  logic             ack;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] high_time;
  logic             valid;
  logic             busy;
  logic             timeout;

  int passes = 0;
  int total  = 0;

  // Waveform generator configuration (written only by the main block).
  int hi_len  = 4;
  int lo_len  = 4;
  int ph0     = 0;
  int epoch   = 0;
  int wave_on = 0;

  period_meter #(.CNT_W(CNT_W), .TMO(64'd64)) dut (
    .clk       (clk),
    .rst       (rst),
    .sig_in    (sig_in),
    .start     (start),
    .ack       (ack),
    .period    (period),
    .high_time (high_time),
    .valid     (valid),
    .busy      (busy),
    .timeout   (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Square-wave source: hi_len cycles high, lo_len low, restarted at phase
  // ph0 whenever the main block bumps epoch. Changes land away from clk edges.
  initial begin : gen
    int ph;
    int seen;
    ph     = 0;
    seen   = 0;
    sig_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (epoch != seen) begin
        seen = epoch;
        ph   = ph0;
      end
      if (wave_on == 0) begin
        sig_in = 1'b0;
      end else begin
        sig_in = (ph < hi_len);
        ph = (ph + 1 >= hi_len + lo_len) ? 0 : ph + 1;
      end
    end
  end

  // Expected high time for a square wave with h high cycles.
  function automatic logic [63:0] exp_high(input int h);
`ifdef PERIOD_METER_DUTY_EN
    return 64'(h);
`else
    return 64'(h - h);
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic set_wave(input int h, input int l);
    hi_len  = h;
    lo_len  = l;
    ph0     = $urandom_range(0, h + l - 1);
    wave_on = 1;
    epoch++;
    repeat (h + l + 6) @(negedge clk);
  endtask

  task automatic wave_off();
    wave_on = 0;
    epoch++;
    repeat (6) @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // Bounded wait for valid; an expired bound is reported as a failed check.
  task automatic wait_valid(input string tag, output int cyc);
    cyc = 0;
    while (valid !== 1'b1 && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk(tag, 64'(valid), 64'd1);
  endtask

  // One complete square-wave measurement with result checks and ack.
  task automatic measure(input string tag, input int h, input int l, input int noise);
    int cyc;
    int extra;
    set_wave(h, l);
    repeat ($urandom_range(0, 4)) @(negedge clk);
    pulse_start();
    if (noise != 0) begin
      @(negedge clk);
      if (busy === 1'b1) begin
        // start and ack while busy must both be ignored
        start = 1'b1;
        ack   = 1'b1;
        @(negedge clk);
        start = 1'b0;
        ack   = 1'b0;
      end
    end
    wait_valid({tag, "_valid"}, cyc);
    chk({tag, "_period"}, 64'(period), 64'(h + l));
    chk({tag, "_high"}, 64'(high_time), exp_high(h));
    chk({tag, "_timeout"}, 64'(timeout), 64'd0);
    pulse_ack();
    chk({tag, "_ackclr"}, 64'(valid), 64'd0);
    extra = 0;
    repeat (h + l + 8) begin
      @(negedge clk);
      if (valid !== 1'b0 || busy !== 1'b0) extra++;
    end
    chk({tag, "_single"}, 64'(extra), 64'd0);
  endtask

  initial begin : main
    int cyc;
    rst   = 1'b0;
    start = 1'b0;
    ack   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_period", 64'(period), 64'd0);
    chk("rst_high", 64'(high_time), 64'd0);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    rst = 1'b1;
    @(negedge clk);

    // 4 high / 4 low square wave
    set_wave(4, 4);
    pulse_start();
    chk("sq44_busy", 64'(busy), 64'd1);
    wait_valid("sq44_valid", cyc);
    chk("sq44_period", 64'(period), 64'd8);
    chk("sq44_high", 64'(high_time), exp_high(4));
    chk("sq44_timeout", 64'(timeout), 64'd0);
    chk("sq44_busy_done", 64'(busy), 64'd0);
    pulse_ack();
    chk("sq44_ackclr", 64'(valid), 64'd0);

    // constant-low input: timeout 64 cycles after entering ARM
    wave_off();
    pulse_start();
    wait_valid("tmo_valid", cyc);
    chk("tmo_latency", 64'(cyc), 64'd64);
    chk("tmo_period", 64'(period), ALL1);
    chk("tmo_high", 64'(high_time), 64'd0);
    chk("tmo_flag", 64'(timeout), 64'd1);

    // start without ack while holding a result is ignored
    set_wave(4, 4);
    pulse_start();
    @(negedge clk);
    chk("hold_valid", 64'(valid), 64'd1);
    chk("hold_busy", 64'(busy), 64'd0);
    chk("hold_period", 64'(period), ALL1);
    chk("hold_timeout", 64'(timeout), 64'd1);
    // ack with start re-arms directly
    start = 1'b1;
    ack   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack   = 1'b0;
    chk("rearm_valid", 64'(valid), 64'd0);
    chk("rearm_busy", 64'(busy), 64'd1);
    wait_valid("rearm_done", cyc);
    chk("rearm_period", 64'(period), 64'd8);
    chk("rearm_timeout", 64'(timeout), 64'd0);
    pulse_ack();

    // short periods
    measure("p3", 2, 1, 0);
    measure("p2", 1, 1, 0);

    // period equal to TMO: closing rise coincides with the limit and wins
    measure("p64", 32, 32, 0);

    // period one beyond TMO: no closing edge in time
    set_wave(33, 32);
    pulse_start();
    wait_valid("p65_valid", cyc);
    chk("p65_period", 64'(period), ALL1);
    chk("p65_high", 64'(high_time), 64'd0);
    chk("p65_timeout", 64'(timeout), 64'd1);
    pulse_ack();

    // randomized square waves, some with start/ack pulsed while busy
    for (int i = 0; i < 12; i++) begin
      measure($sformatf("rnd%0d", i), int'($urandom_range(1, 12)),
              int'($urandom_range(1, 12)), i % 3);
    end

    // asynchronous reset in the middle of a measurement
    set_wave(10, 10);
    pulse_start();
    repeat (22) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mrst_period", 64'(period), 64'd0);
    chk("mrst_high", 64'(high_time), 64'd0);
    chk("mrst_valid", 64'(valid), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    chk("mrst_timeout", 64'(timeout), 64'd0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    measure("post_rst", 6, 3, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end

  // Absolute guard against a hung run.
  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1, "watchdog");
  end

endmodule
